// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq
//
// Host-side command sequencer that sits in front of RemoteComm. It buffers
// 16-bit Knight commands in a small FIFO and issues them one at a time,
// waiting for a positive acknowledge byte before moving on. A NAK or a
// response timeout parks the sequencer in ERR until clr_err or abort.
//
// Parameters
//   DEPTH    command FIFO depth (power of 2)
//   TO_W     width of the response timeout counter
//   TIMEOUT  clocks allowed from the SEND cycle to a response
//   ACK      positive-acknowledge byte
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   wr_cmd, wdata       enqueue a command (dropped when full, unless popping)
//   run                 level; drain the FIFO while high (sampled in IDLE)
//   abort               flush FIFO, clear error, return to IDLE
//   clr_err             leave ERR with the FIFO intact
//   cmd, snd_cmd        command and one-cycle send strobe to RemoteComm
//   cmd_snt             RemoteComm finished transmitting
//   resp_rdy, resp      response byte and its valid strobe
//   full, empty, count  FIFO status, decoded from the pointers
//   busy                a command is in flight
//   ack_pulse           one cycle per acknowledged command
//   cmds_done           acknowledged-command count, saturating at 255
//   err, err_code       ERR state flag and cause (01 NAK, 10 timeout)

module remote_cmd_seq #(
   parameter int              DEPTH   = 8,
   parameter int              TO_W    = 26,
   parameter logic [TO_W-1:0] TIMEOUT = 26'd50_000_000,
   parameter logic [7:0]      ACK     = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_cmd,
   input  logic [15:0]              wdata,
   input  logic                     run,
   input  logic                     abort,
   input  logic                     clr_err,
   output logic [15:0]              cmd,
   output logic                     snd_cmd,
   input  logic                     cmd_snt,
   input  logic                     resp_rdy,
   input  logic [7:0]               resp,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     ack_pulse,
   output logic [7:0]               cmds_done,
   output logic                     err,
   output logic [1:0]               err_code
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // The counter is loaded with 1 as SEND is left, so it holds the number of
   // cycles elapsed since the SEND cycle; matching TIMEOUT-1 in a wait state
   // puts the ERR edge exactly TIMEOUT cycles after SEND.
   localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_ONE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SNT,
      S_WAIT_RESP,
      S_ERR
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            pop;
   logic            push_ok;
   logic            ack_hit;
   logic            nak_hit;
   logic            to_hit;
   logic            to_expired;
   logic [TO_W-1:0] to_cnt;

   logic [15:0]     mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == CW'(DEPTH));

   // A push into a full FIFO is still accepted when the same cycle pops.
   assign push_ok = wr_cmd && (!full || pop) && !abort;

   assign to_expired = (to_cnt == TO_LAST);

   // NOTE: every combinational output gets a default first, so no path
   // through the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      ack_hit    = 1'b0;
      nak_hit    = 1'b0;
      to_hit     = 1'b0;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (run && !empty) begin
                  pop        = 1'b1;
                  next_state = S_SEND;
               end
            end
            S_SEND: next_state = S_WAIT_SNT;
            S_WAIT_SNT: begin
               // Any resp_rdy before the command is on the wire is ignored.
               if (to_expired) begin
                  to_hit     = 1'b1;
                  next_state = S_ERR;
               end else if (cmd_snt) begin
                  next_state = S_WAIT_RESP;
               end
            end
            S_WAIT_RESP: begin
               // A response in the same cycle as the timeout takes precedence.
               if (resp_rdy) begin
                  if (resp == ACK) begin
                     ack_hit    = 1'b1;
                     next_state = S_IDLE;
                  end else begin
                     nak_hit    = 1'b1;
                     next_state = S_ERR;
                  end
               end else if (to_expired) begin
                  to_hit     = 1'b1;
                  next_state = S_ERR;
               end
            end
            S_ERR: begin
               if (clr_err) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd       <= '0;
         snd_cmd   <= 1'b0;
         ack_pulse <= 1'b0;
         cmds_done <= '0;
         err       <= 1'b0;
         err_code  <= 2'b00;
         busy      <= 1'b0;
         to_cnt    <= '0;
      end else begin
         state     <= next_state;
         snd_cmd   <= (next_state == S_SEND);
         busy      <= (next_state == S_SEND) || (next_state == S_WAIT_SNT) ||
                      (next_state == S_WAIT_RESP);
         err       <= (next_state == S_ERR);
         ack_pulse <= ack_hit;

         if (ack_hit && (cmds_done != 8'hFF)) cmds_done <= cmds_done + 8'd1;

         if (abort || ((state == S_ERR) && clr_err)) err_code <= 2'b00;
         else if (nak_hit)                           err_code <= 2'b01;
         else if (to_hit)                            err_code <= 2'b10;

         if (state == S_SEND)
            to_cnt <= TO_ONE;
         else if ((state == S_WAIT_SNT) || (state == S_WAIT_RESP))
            to_cnt <= to_cnt + TO_ONE;

         // Abort empties the queue but leaves cmd showing the last command.
         if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
         end

         if (pop) cmd <= mem[rd_ptr[AW-1:0]];
      end
   end

   // NOTE: the storage array has no reset; only the pointers define which
   // entries are valid, so clearing the data would cost logic for nothing.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb_remote_cmd_seq
//
// Directed bench for remote_cmd_seq. The bench plays the role of RemoteComm:
// after each snd_cmd it pulses cmd_snt, then returns a response byte about
// 50 clocks later. TIMEOUT is shortened to 100 clocks. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.

module tb_remote_cmd_seq;

   localparam int DEPTH = 8;
   localparam int TO_W  = 26;

   logic                    clk;
   logic                    rst_n;
   logic                    wr_cmd;
   logic [15:0]             wdata;
   logic                    run;
   logic                    abort;
   logic                    clr_err;
   logic [15:0]             cmd;
   logic                    snd_cmd;
   logic                    cmd_snt;
   logic                    resp_rdy;
   logic [7:0]              resp;
   logic                    full;
   logic                    empty;
   logic [$clog2(DEPTH):0]  count;
   logic                    busy;
   logic                    ack_pulse;
   logic [7:0]              cmds_done;
   logic                    err;
   logic [1:0]              err_code;

   int checks = 0;
   int errors = 0;

   remote_cmd_seq #(
      .DEPTH   (DEPTH),
      .TO_W    (TO_W),
      .TIMEOUT (26'd100),
      .ACK     (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_cmd    (wr_cmd),
      .wdata     (wdata),
      .run       (run),
      .abort     (abort),
      .clr_err   (clr_err),
      .cmd       (cmd),
      .snd_cmd   (snd_cmd),
      .cmd_snt   (cmd_snt),
      .resp_rdy  (resp_rdy),
      .resp      (resp),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .busy      (busy),
      .ack_pulse (ack_pulse),
      .cmds_done (cmds_done),
      .err       (err),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      wr_cmd   = 1'b0;
      wdata    = '0;
      run      = 1'b0;
      abort    = 1'b0;
      clr_err  = 1'b0;
      cmd_snt  = 1'b0;
      resp_rdy = 1'b0;
      resp     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [15:0] d);
      wdata  = d;
      wr_cmd = 1'b1;
      @(negedge clk);
      wr_cmd = 1'b0;
   endtask

   // Bounded wait for a send strobe; n is the number of falling edges taken.
   task automatic wait_snd(input int max_cyc, output int n);
      n = 0;
      while (snd_cmd !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
   endtask

   // RemoteComm stand-in: called on the falling edge where snd_cmd is seen.
   // Returns on the falling edge just after the response was consumed.
   task automatic serve(input logic [7:0] b);
      repeat (3) @(negedge clk);
      cmd_snt = 1'b1;
      @(negedge clk);
      cmd_snt = 1'b0;
      repeat (49) @(negedge clk);
      resp     = b;
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
   endtask

   initial begin
      int          n;
      logic        saw_snd;
      logic [15:0] exp_cmd;

      // ---------------- reset values
      do_reset();
      check("rst_cmd", cmd, 16'h0000);
      check("rst_snd_cmd", snd_cmd, 1'b0);
      check("rst_ack_pulse", ack_pulse, 1'b0);
      check("rst_cmds_done", cmds_done, 8'd0);
      check("rst_err", err, 1'b0);
      check("rst_err_code", err_code, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_count", count, 4'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);

      // ---------------- 1: two-command queue, both acked
      push(16'h2000);
      push(16'h47F3);
      check("t1_count_queued", count, 4'd2);
      run = 1'b1;
      wait_snd(10, n);
      check("t1_snd1", snd_cmd, 1'b1);
      check("t1_cmd1", cmd, 16'h2000);
      check("t1_busy", busy, 1'b1);
      check("t1_count_after_pop", count, 4'd1);
      serve(8'hA5);
      check("t1_ack1", ack_pulse, 1'b1);
      check("t1_done1", cmds_done, 8'd1);
      check("t1_no_snd_in_idle", snd_cmd, 1'b0);
      @(negedge clk);
      check("t1_snd2_two_after_ack", snd_cmd, 1'b1);
      check("t1_cmd2", cmd, 16'h47F3);
      check("t1_ack_one_cycle", ack_pulse, 1'b0);
      serve(8'hA5);
      check("t1_ack2", ack_pulse, 1'b1);
      check("t1_done2", cmds_done, 8'd2);
      check("t1_empty", empty, 1'b1);
      check("t1_busy_end", busy, 1'b0);

      // ---------------- 2: NAK, then clear
      do_reset();
      push(16'h2000);
      push(16'h4711);
      run = 1'b1;
      wait_snd(10, n);
      check("t2_snd1", snd_cmd, 1'b1);
      check("t2_cmd1", cmd, 16'h2000);
      serve(8'h5A);
      check("t2_err", err, 1'b1);
      check("t2_err_code_nak", err_code, 2'b01);
      check("t2_busy", busy, 1'b0);
      check("t2_count", count, 4'd1);
      saw_snd = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (snd_cmd === 1'b1) saw_snd = 1'b1;
      end
      check("t2_no_snd_in_err", saw_snd, 1'b0);
      check("t2_err_held", err, 1'b1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t2_err_cleared", err, 1'b0);
      check("t2_err_code_cleared", err_code, 2'b00);
      wait_snd(5, n);
      check("t2_snd2", snd_cmd, 1'b1);
      check("t2_cmd2", cmd, 16'h4711);
      serve(8'hA5);
      check("t2_ack", ack_pulse, 1'b1);
      check("t2_done", cmds_done, 8'd1);

      // ---------------- 3: response timeout, then abort out of ERR
      do_reset();
      push(16'h2000);
      run = 1'b1;
      wait_snd(10, n);
      check("t3_snd", snd_cmd, 1'b1);
      repeat (3) @(negedge clk);
      cmd_snt = 1'b1;
      @(negedge clk);
      cmd_snt = 1'b0;
      n = 4;
      while (err !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t3_timeout_cycles", n, 100);
      check("t3_err_code_to", err_code, 2'b10);
      check("t3_busy", busy, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t3_abort_err", err, 1'b0);
      check("t3_abort_err_code", err_code, 2'b00);

      // ---------------- 4: FIFO full and push during pop
      do_reset();
      for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i));
      check("t4_count_full", count, 4'd8);
      check("t4_full", full, 1'b1);
      check("t4_not_empty", empty, 1'b0);
      run    = 1'b1;
      wdata  = 16'h10AA;
      wr_cmd = 1'b1;
      @(negedge clk);
      wr_cmd = 1'b0;
      check("t4_snd_first", snd_cmd, 1'b1);
      check("t4_cmd_first", cmd, 16'h1000);
      check("t4_count_pushpop", count, 4'd8);
      check("t4_still_full", full, 1'b1);
      serve(8'hA5);
      for (int i = 1; i < 9; i++) begin
         exp_cmd = (i < 8) ? (16'h1000 + 16'(i)) : 16'h10AA;
         wait_snd(10, n);
         check($sformatf("t4_snd_%0d", i), snd_cmd, 1'b1);
         check($sformatf("t4_order_%0d", i), cmd, exp_cmd);
         serve(8'hA5);
      end
      check("t4_done", cmds_done, 8'd9);
      check("t4_empty_end", empty, 1'b1);

      // ---------------- 5: abort mid-response
      do_reset();
      push(16'h2000);
      push(16'h3001);
      push(16'h3002);
      push(16'h3003);
      run = 1'b1;
      wait_snd(10, n);
      check("t5_cmd", cmd, 16'h2000);
      repeat (2) @(negedge clk);
      cmd_snt = 1'b1;
      @(negedge clk);
      cmd_snt = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_busy_wait_resp", busy, 1'b1);
      check("t5_count_queued", count, 4'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_idle_after_abort", busy, 1'b0);
      check("t5_count_flushed", count, 4'd0);
      check("t5_empty", empty, 1'b1);
      check("t5_err", err, 1'b0);
      check("t5_cmd_retained", cmd, 16'h2000);
      resp     = 8'hA5;
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
      check("t5_late_ack_ignored", ack_pulse, 1'b0);
      check("t5_done_unchanged", cmds_done, 8'd0);
      saw_snd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (snd_cmd === 1'b1) saw_snd = 1'b1;
      end
      check("t5_no_snd_after_abort", saw_snd, 1'b0);

      // ---------------- 6: run dropped mid-command
      do_reset();
      run = 1'b1;
      @(negedge clk);
      wdata  = 16'h47F3;
      wr_cmd = 1'b1;
      @(negedge clk);
      wr_cmd = 1'b0;
      check("t6_snd_not_yet", snd_cmd, 1'b0);
      @(negedge clk);
      check("t6_write_to_send", snd_cmd, 1'b1);
      check("t6_cmd1", cmd, 16'h47F3);
      wdata  = 16'h5522;
      wr_cmd = 1'b1;
      @(negedge clk);
      wr_cmd = 1'b0;
      run    = 1'b0;
      serve(8'hA5);
      check("t6_ack", ack_pulse, 1'b1);
      check("t6_done1", cmds_done, 8'd1);
      saw_snd = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (snd_cmd === 1'b1) saw_snd = 1'b1;
      end
      check("t6_no_snd_while_stopped", saw_snd, 1'b0);
      check("t6_count_held", count, 4'd1);
      run = 1'b1;
      wait_snd(5, n);
      check("t6_snd2", snd_cmd, 1'b1);
      check("t6_cmd2", cmd, 16'h5522);
      serve(8'hA5);
      check("t6_done2", cmds_done, 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
